// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Holds the controller state encoding, the Booth pair codes and the iteration count rule.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } booth_state_t;

  // Booth pair {Q[0], q-1}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  // Unsigned operands need one extra step to consume the zero-extension bit of Q.
  function automatic int booth_iters(input int yw, input logic sgn);
    return sgn ? yw : yw + 1;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/result bundle between a multiply master and booth_mult_seq.
interface booth_mult_seq_if #(
  parameter int XW = 6,
  parameter int YW = 6
);

  logic              start;
  logic              sgn;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              ready;
  logic              busy;
  logic              done;
  logic [XW+YW-1:0]  product;

  modport master (
    output start, sgn, x, y,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, sgn, x, y,
    output ready, busy, done, product
  );

endinterface

// File: rtl/booth_step.sv
// One combinational Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of the combined {A, Q, q-1} register.
module booth_step
  import booth_pkg::*;
#(
  parameter int XW = 6,
  parameter int YW = 6
) (
  input  logic [XW+1:0] a,
  input  logic [YW:0]   q,
  input  logic          qm1,
  input  logic [XW:0]   m,
  output logic [XW+1:0] a_nxt,
  output logic [YW:0]   q_nxt,
  output logic          qm1_nxt
);

  logic [XW+1:0] m_ext;
  logic [XW+1:0] sum;

  // M is already sign- or zero-extended, so copying its top bit is correct in both modes.
  assign m_ext = {m[XW], m};

  always_comb begin
    sum = a;
    case ({q[0], qm1})
      ADD:     sum = a + m_ext;
      SUB:     sum = a - m_ext;
      NOP:     sum = a;
      default: sum = a;
    endcase
    {a_nxt, q_nxt, qm1_nxt} = {sum[XW+1], sum, q};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: IDLE/LOAD/ITER/DONE controller around booth_step,
// retiring one Booth step per clock and holding the product until the next result.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int XW = 6,
  parameter int YW = 6
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_seq_if.slave  bus
);

  localparam int PW = XW + YW;
  localparam int CW = $clog2(YW + 2);

  booth_state_t state, state_nxt;
  logic         accept;

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          sgn_r;

  logic [XW+1:0] a, a_nxt;
  logic [YW:0]   q, q_nxt;
  logic          qm1, qm1_nxt;
  logic [XW:0]   m;
  logic [CW-1:0] cnt;
  logic [PW-1:0] product_r;

  booth_step #(
    .XW(XW),
    .YW(YW)
  ) u_step (
    .a       (a),
    .q       (q),
    .qm1     (qm1),
    .m       (m),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .qm1_nxt (qm1_nxt)
  );

  // A new operation is accepted only from the two ready states.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end
      end
      LOAD: state_nxt = ITER;
      ITER: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      sgn_r     <= 1'b0;
      a         <= '0;
      q         <= '0;
      qm1       <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_r   <= bus.x;
        y_r   <= bus.y;
        sgn_r <= bus.sgn;
      end
      if (state == LOAD) begin
        a   <= '0;
        q   <= sgn_r ? {y_r[YW-1], y_r} : {1'b0, y_r};
        m   <= sgn_r ? {x_r[XW-1], x_r} : {1'b0, x_r};
        qm1 <= 1'b0;
        cnt <= CW'(booth_iters(YW, sgn_r));
      end else if (state == ITER) begin
        a   <= a_nxt;
        q   <= q_nxt;
        qm1 <= qm1_nxt;
        cnt <= cnt - CW'(1);
        // Signed runs leave the sign-extension bit in Q[0]; unsigned runs consume all of Q.
        if (cnt == CW'(1)) begin
          product_r <= sgn_r ? PW'({a_nxt, q_nxt[YW:1]}) : PW'({a_nxt, q_nxt});
        end
      end
    end
  end

  assign bus.ready   = (state == IDLE) || (state == DONE);
  assign bus.busy    = (state == LOAD) || (state == ITER);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;

endmodule
